// File: rtl/ram_reg_param_if.sv
// Access bus between a simple master and ram_reg_param: strobe, write enable,
// address and write data in one direction; read data and status flags back.
interface ram_reg_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              EN;
  logic              WE;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
  logic              QValid;
  logic              busy;
  logic              WErr;

  modport master (
    output EN, WE, address, D,
    input  Q, QValid, busy, WErr
  );

  modport slave (
    input  EN, WE, address, D,
    output Q, QValid, busy, WErr
  );
endinterface

// File: rtl/ram_reg_param.sv
// Single-port synchronous RAM with a post-reset fill sequencer, a read-only
// low-address region and a one-cycle registered read port.
module ram_reg_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int INIT_MODE  = 0,
  parameter int PROT_N     = 0,
  parameter int WR_THROUGH = 0
) (
  input  logic            clock,
  input  logic            reset,
  ram_reg_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                qvalid_q, qvalid_d;
  logic                werr_q, werr_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   pattern;
  logic [DATA_W-1:0]   rd_word;
  logic                prot_hit;
  logic                init_last;

  // Fill pattern per bit: index mode zero-extends or truncates the counter.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pat
    if (INIT_MODE == 1) begin : g_idx
      if (gi < ADDR_W) begin : g_bit
        assign pattern[gi] = cnt_q[gi];
      end else begin : g_pad
        assign pattern[gi] = 1'b0;
      end
    end else if (INIT_MODE == 2) begin : g_ones
      assign pattern[gi] = 1'b1;
    end else begin : g_zero
      assign pattern[gi] = 1'b0;
    end
  end

  if (PROT_N <= 0) begin : g_prot_none
    assign prot_hit = 1'b0;
  end else if (PROT_N >= DEPTH) begin : g_prot_all
    assign prot_hit = 1'b1;
  end else begin : g_prot_low
    assign prot_hit = (bus.address < ADDR_W'(PROT_N));
  end

  assign init_last = &cnt_q;
  assign rd_word   = mem_q[bus.address];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    qvalid_d  = 1'b0;
    werr_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    mem_wdata = bus.D;

    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = pattern;
      werr_d    = bus.EN & bus.WE;
      if (init_last) begin
        state_d = ST_READY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.EN) begin
      if (bus.WE) begin
        if (prot_hit) begin
          werr_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          if (WR_THROUGH != 0) begin
            q_d      = bus.D;
            qvalid_d = 1'b1;
          end
        end
      end else begin
        q_d      = rd_word;
        qvalid_d = 1'b1;
      end
    end

    // Reset wins over both the sequencer and any user access on that edge.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      q_q      <= '0;
      qvalid_q <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qvalid_q <= qvalid_d;
      werr_q   <= werr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.Q      = q_q;
  assign bus.QValid = qvalid_q;
  assign bus.WErr   = werr_q;
  assign bus.busy   = (state_q == ST_INIT);
endmodule

// File: tb/tb_ram_reg_param.sv
// Directed bench for ram_reg_param: instance A (index fill, protection, no
// write-through) and instance B (ones fill, no protection, write-through).
module tb_ram_reg_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       we = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] d = '0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ram_reg_param_if #(.DATA_W(8), .ADDR_W(5)) if_a ();
  ram_reg_param_if #(.DATA_W(8), .ADDR_W(5)) if_b ();

  assign if_a.EN = en;
  assign if_a.WE = we;
  assign if_a.address = addr;
  assign if_a.D = d;
  assign if_b.EN = en;
  assign if_b.WE = we;
  assign if_b.address = addr;
  assign if_b.D = d;

  ram_reg_param #(.DATA_W(8), .ADDR_W(5), .INIT_MODE(1), .PROT_N(5), .WR_THROUGH(0)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (if_a.slave)
  );

  ram_reg_param #(.DATA_W(8), .ADDR_W(5), .INIT_MODE(2), .PROT_N(0), .WR_THROUGH(1)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (if_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic e, input logic w, input logic [4:0] a, input logic [7:0] dd);
    en = e;
    we = w;
    addr = a;
    d = dd;
    tick();
  endtask

  // Checks both instances after one access: Q, QValid, WErr for each.
  task automatic both(input string tag,
                      input logic [7:0] qa, input logic va, input logic ea,
                      input logic [7:0] qb, input logic vb, input logic eb);
    chk({tag, "_qa"}, if_a.Q, qa);
    chk({tag, "_va"}, if_a.QValid, va);
    chk({tag, "_ea"}, if_a.WErr, ea);
    chk({tag, "_qb"}, if_b.Q, qb);
    chk({tag, "_vb"}, if_b.QValid, vb);
    chk({tag, "_eb"}, if_b.WErr, eb);
    $display("step %s: A Q=%h V=%b E=%b | B Q=%h V=%b E=%b", tag,
             if_a.Q, if_a.QValid, if_a.WErr, if_b.Q, if_b.QValid, if_b.WErr);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    both("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_busy_a", if_a.busy, 1);
    chk("reset_busy_b", if_b.busy, 1);

    // Init fill with a write attempt on edge 3
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 3) begin
        en = 1'b1; we = 1'b1; addr = 5'd20; d = 8'h11;
      end else begin
        en = 1'b0; we = 1'b0;
      end
      tick();
      chk("init_busy_a", if_a.busy, 32'(i < 32));
      chk("init_busy_b", if_b.busy, 32'(i < 32));
      if (i == 3) both("busy_write", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      if (i == 4) both("busy_after", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Reads of the fill pattern
    access(1'b1, 1'b0, 5'd0, 8'h00);
    both("rd0", 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd7, 8'h00);
    both("rd7", 8'h07, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd31, 8'h00);
    both("rd31", 8'h1F, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd20, 8'h00);
    both("rd20", 8'h14, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

    // Protection (A) versus plain write-through (B)
    access(1'b1, 1'b1, 5'd2, 8'hAA);
    both("wr2", 8'h14, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd2, 8'h00);
    both("rd2", 8'h02, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
    access(1'b1, 1'b1, 5'd5, 8'h55);
    both("wr5", 8'h02, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd5, 8'h00);
    both("rd5", 8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0);

    // Write-through difference
    access(1'b1, 1'b1, 5'd9, 8'hC3);
    both("wr9", 8'h55, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);

    // Idle holds Q
    access(1'b0, 1'b0, 5'd9, 8'h00);
    both("idle", 8'h55, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
    access(1'b1, 1'b0, 5'd9, 8'h00);
    both("rd9", 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);

    // Back-to-back write then reads
    access(1'b1, 1'b1, 5'd12, 8'h3C);
    both("wr12", 8'hC3, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd12, 8'h00);
    both("rd12", 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
    access(1'b1, 1'b0, 5'd13, 8'h00);
    both("rd13", 8'h0D, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

    // Reset in READY, then reset again mid-init
    en = 1'b0; we = 1'b0;
    rst = 1'b1;
    tick();
    both("rst2", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst2_busy_a", if_a.busy, 1);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst3_busy_a", if_a.busy, 1);
    chk("rst3_q_a", if_a.Q, 8'h00);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i >= 31) begin
        chk("reinit_busy_a", if_a.busy, 32'(i < 32));
        chk("reinit_busy_b", if_b.busy, 32'(i < 32));
      end
    end
    chk("reinit_q_a", if_a.Q, 8'h00);

    // Whole array holds the pattern again; user writes are gone
    for (int i = 0; i < 32; i++) begin
      access(1'b1, 1'b0, 5'(i), 8'h00);
      chk("fill_qa", if_a.Q, 32'(i));
      chk("fill_va", if_a.QValid, 1);
      chk("fill_qb", if_b.Q, 8'hFF);
    end
    $display("step refill: checked 32 addresses on both instances");

    en = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
